hilo_muldiv_unit: RTL



---
 rtl/hilo_muldiv_unit.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - HI/LO unit: mf/mt moves plus iterative mult/div (MULDIV_FAST_MULT_EN: 1-cycle mult)
module hilo_muldiv_unit #(
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        hold,
    input  logic [7:0]  hilo_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic        stallreq,
    output logic        hi_we,
    output logic [31:0] hi_o,
    output logic        lo_we,
    output logic [31:0] lo_o,
    output logic [31:0] rd_data
);

    typedef enum logic [1:0] {S_IDLE, S_MUL_RUN, S_DIV_RUN, S_DONE} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [63:0]        r_prod;
    logic [32:0]        r_rem;
    logic [31:0]        r_quo;
    logic [31:0]        r_raw_a;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic [7:0]  w_op;
    logic        w_signed, w_is_mul, w_is_div, w_start, w_last;
    logic [31:0] w_abs_a, w_abs_b;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next, w_prod_fix;
    logic [33:0] w_div_shift, w_div_diff;
    logic        w_div_ge;
    logic [32:0] w_rem_next;
    logic [31:0] w_quo_next, w_quo_fix, w_rem_fix;

    // Highest set bit of hilo_op selects the operation.
    always_comb begin
        w_op = 8'b0;
        casez (hilo_op)
            8'b1???????: w_op = 8'b1000_0000;
            8'b01??????: w_op = 8'b0100_0000;
            8'b001?????: w_op = 8'b0010_0000;
            8'b0001????: w_op = 8'b0001_0000;
            8'b00001???: w_op = 8'b0000_1000;
            8'b000001??: w_op = 8'b0000_0100;
            8'b0000001?: w_op = 8'b0000_0010;
            8'b00000001: w_op = 8'b0000_0001;
            default:     w_op = 8'b0;
        endcase
    end

    assign w_signed = w_op[3] | w_op[1];
    assign w_is_mul = w_op[3] | w_op[2];
    assign w_is_div = w_op[1] | w_op[0];
`ifdef MULDIV_FAST_MULT_EN
    assign w_start  = w_is_div;
`else
    assign w_start  = w_is_mul | w_is_div;
`endif
    assign w_abs_a  = (w_signed && src_a[31]) ? -src_a : src_a;
    assign w_abs_b  = (w_signed && src_b[31]) ? -src_b : src_b;
    assign w_last   = (r_cnt == CNT_W'(31));

    // Shift-add: low half of r_prod holds the unconsumed multiplier bits.
    assign w_mul_sum  = {1'b0, r_prod[63:32]} + {1'b0, r_a};
    assign w_mul_next = r_prod[0] ? {w_mul_sum, r_prod[31:1]} : {1'b0, r_prod[63:1]};
    assign w_prod_fix = r_neg_q ? -w_mul_next : w_mul_next;

    assign w_div_shift = {r_rem, r_quo[31]};
    assign w_div_diff  = w_div_shift - {2'b0, r_b};
    assign w_div_ge    = ~w_div_diff[33];
    assign w_rem_next  = w_div_ge ? w_div_diff[32:0] : w_div_shift[32:0];
    assign w_quo_next  = {r_quo[30:0], w_div_ge};
    assign w_quo_fix   = r_dz ? 32'hFFFF_FFFF : (r_neg_q ? -w_quo_next : w_quo_next);
    assign w_rem_fix   = r_dz ? r_raw_a : (r_neg_r ? -w_rem_next[31:0] : w_rem_next[31:0]);

`ifdef MULDIV_FAST_MULT_EN
    logic [63:0] w_ext_a, w_ext_b, w_fast_prod;
    assign w_ext_a     = {{32{w_op[3] & src_a[31]}}, src_a};
    assign w_ext_b     = {{32{w_op[3] & src_b[31]}}, src_b};
    assign w_fast_prod = w_ext_a * w_ext_b;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_prod  <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_raw_a <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_a     <= w_abs_a;
                    r_b     <= w_abs_b;
                    r_prod  <= {32'b0, w_abs_b};
                    r_quo   <= w_abs_a;
                    r_rem   <= '0;
                    r_raw_a <= src_a;
                    r_neg_q <= w_signed & (src_a[31] ^ src_b[31]);
                    r_neg_r <= w_signed & src_a[31];
                    r_dz    <= w_is_div & (src_b == 32'b0);
                    r_cnt   <= '0;
                    r_state <= w_is_div ? S_DIV_RUN : S_MUL_RUN;
                end
                S_MUL_RUN: begin
                    r_prod <= w_mul_next;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_hi    <= w_prod_fix[63:32];
                        r_lo    <= w_prod_fix[31:0];
                        r_state <= S_DONE;
                    end
                end
                S_DIV_RUN: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_hi    <= w_rem_fix;
                        r_lo    <= w_quo_fix;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: if (!hold) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        stallreq = 1'b0;
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        hi_o     = 32'b0;
        lo_o     = 32'b0;
        rd_data  = 32'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (w_op[7]) rd_data = hi_i;
                    if (w_op[6]) rd_data = lo_i;
                    if (w_op[5] && !flush) begin
                        hi_we = 1'b1;
                        hi_o  = src_a;
                    end
                    if (w_op[4] && !flush) begin
                        lo_we = 1'b1;
                        lo_o  = src_a;
                    end
`ifdef MULDIV_FAST_MULT_EN
                    if (w_is_mul && !flush) begin
                        hi_we = 1'b1;
                        lo_we = 1'b1;
                        hi_o  = w_fast_prod[63:32];
                        lo_o  = w_fast_prod[31:0];
                    end
`endif
                    stallreq = w_start & ~flush;
                end
                S_MUL_RUN, S_DIV_RUN: stallreq = ~flush;
                S_DONE: if (!flush) begin
                    hi_we = 1'b1;
                    lo_we = 1'b1;
                    hi_o  = r_hi;
                    lo_o  = r_lo;
                end
                default: stallreq = 1'b0;
            endcase
        end
    end

endmodule
